// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the framed serial pattern transmitter.
// Holds the FSM state enum, the preamble pattern and a sizing helper.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        PAY,
        GAP
    } seq_gen_state_e;

    // Preamble is sent MSB first: 1, 0, 1.
    localparam logic [2:0] PREAMBLE     = 3'b101;
    localparam int         PREAMBLE_LEN = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/seq_gen_shifter.sv
// Parallel-load, shift-left payload register (zero fill), MSB out.
// Ports: clk, rst (async high), load+din, shift, msb.
module seq_gen_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/seq_generator.sv
// Framed serial transmitter: 101 preamble, MSB-first payload, idle gap.
// Ports: clk, rst, in_data/in_valid/in_ready, abort, tx_bit, tx_active, frame_done.
module seq_generator
    import seq_gen_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             tx_bit,
    output logic             tx_active,
    output logic             frame_done
);

    localparam int CNT_W =
        $clog2(max3(WIDTH, GAP_CYCLES, PREAMBLE_LEN)) + 1;

    localparam logic [CNT_W-1:0] PRE_LAST =
        CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_LAST =
        CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Where a frame goes once it ends or is aborted.
    localparam seq_gen_state_e END_STATE =
        (GAP_CYCLES == 0) ? IDLE : GAP;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("seq_generator: WIDTH must be 1..32");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("seq_generator: GAP_CYCLES must be 0..15");
    end

    seq_gen_state_e   state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             shift;
    logic             sr_msb;
    logic [1:0]       pre_idx;

    assign load  = (state == IDLE) && in_valid;
    assign shift = (state == PAY);

    seq_gen_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (in_data),
        .msb   (sr_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= PRE;
                        cnt   <= '0;
                    end
                end
                PRE: begin
                    if (abort) begin
                        state <= END_STATE;
                        cnt   <= '0;
                    end else if (cnt == PRE_LAST) begin
                        state <= PAY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PAY: begin
                    if (abort || cnt == PAY_LAST) begin
                        state <= END_STATE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Counter 0,1,2 selects preamble bits [2],[1],[0].
    assign pre_idx = 2'(PREAMBLE_LEN - 1) - cnt[1:0];

    always_comb begin
        tx_bit     = 1'b0;
        tx_active  = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            PRE: begin
                tx_bit    = PREAMBLE[pre_idx];
                tx_active = 1'b1;
            end
            PAY: begin
                tx_bit     = sr_msb;
                tx_active  = 1'b1;
                frame_done = (cnt == PAY_LAST);
            end
            default: begin
                tx_bit = 1'b0;
            end
        endcase
    end

    // Held low while reset is asserted; high as soon as it releases.
    assign in_ready = (state == IDLE) && !rst;

endmodule
